imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 179 +++++++++++++++++
 tb/tb_imem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: one outstanding fetch with a fixed read latency,
// fault flagging for misaligned or out-of-range addresses, and a program-load write port.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_instr,
    output logic        resp_fault,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [1:0]  state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic [31:0] addr_r, addr_nx_s;
    logic        req_ready_s, accept_s, start_s, load_resp_s, clear_resp_s;
    logic [31:0] rd_addr_s, rd_instr_s;
    logic        rd_fault_s;
    logic        resp_valid_r, resp_fault_r;
    logic [31:0] resp_addr_r, resp_instr_r;

    // Misaligned or beyond the last word: such addresses never touch the array
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH_W);
    endfunction

    // Request handshake: free when idle, or when the held response retires this cycle
    always_comb begin
        req_ready_s = 1'b0;
        if (reset || flush) begin
            req_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            req_ready_s = 1'b1;
        end else if (state_r == ST_RESP) begin
            req_ready_s = resp_ready;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s = req_valid & req_ready_s;

    // Next-state, counter and read-port control; flush discards everything in flight
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        addr_nx_s    = addr_r;
        start_s      = 1'b0;
        load_resp_s  = 1'b0;
        clear_resp_s = 1'b0;
        rd_addr_s    = addr_r;
        if (flush) begin
            state_nx_s   = ST_IDLE;
            cnt_nx_s     = 4'd0;
            addr_nx_s    = 32'd0;
            clear_resp_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        start_s = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_nx_s = (cnt_r != 4'd0) ? (cnt_r - 4'd1) : 4'd0;
                    // Counter reaching zero on this edge completes the latency
                    if (cnt_r <= 4'd1) begin
                        state_nx_s  = ST_RESP;
                        load_resp_s = 1'b1;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        clear_resp_s = 1'b1;
                        if (accept_s) begin
                            start_s = 1'b1;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        state_nx_s = ST_RESP;
                    end
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    clear_resp_s = 1'b1;
                end
            endcase
            if (start_s) begin
                addr_nx_s = req_addr;
                cnt_nx_s  = LAT_INIT;
                if (LATENCY == 1) begin
                    state_nx_s  = ST_RESP;
                    load_resp_s = 1'b1;
                    rd_addr_s   = req_addr;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end else begin
                rd_addr_s = addr_r;
            end
        end
    end

    // Read data selection: faulting addresses return NOP without indexing memory
    always_comb begin
        rd_fault_s = addr_bad(rd_addr_s);
        if (rd_fault_s) begin
            rd_instr_s = NOP;
        end else begin
            rd_instr_s = mem_r[rd_addr_s[AW+1:2]];
        end
    end

    // Program-load port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (load_we && !addr_bad(load_addr)) begin
            mem_r[load_addr[AW+1:2]] <= load_data;
        end
    end

    // FSM state and registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_addr_r  <= 32'd0;
            resp_instr_r <= NOP;
            resp_fault_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            addr_r  <= addr_nx_s;
            if (load_resp_s) begin
                resp_valid_r <= 1'b1;
                resp_addr_r  <= rd_addr_s;
                resp_instr_r <= rd_instr_s;
                resp_fault_r <= rd_fault_s;
            end else if (clear_resp_s) begin
                resp_valid_r <= 1'b0;
                resp_addr_r  <= 32'd0;
                resp_instr_r <= NOP;
                resp_fault_r <= 1'b0;
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_r;
    assign resp_addr  = resp_addr_r;
    assign resp_instr = resp_instr_r;
    assign resp_fault = resp_fault_r;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed fetch/load/flush/reset scenarios checked against a
// transaction-level model every cycle, plus hand-computed literal expectations.
module tb_imem_responder;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_addr;
    logic [31:0] resp_instr;
    logic        resp_fault;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [31:0] load_data = 32'd0;

    int total = 0;
    int bad   = 0;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_instr(resp_instr), .resp_fault(resp_fault),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Transaction-level model: one pending fetch, visible LAT cycles after its accept cycle
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_out = 1'b0;
    bit          m_fault = 1'b0;
    bit          m_ikn = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_instr = 32'd0;
    int          m_ready_at = 0;
    int          m_cyc = 0;

    function automatic bit bad_addr(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    always @(negedge clk) begin
        bit ev;
        bit er;
        ev = m_out && (m_cyc >= m_ready_at);
        er = !reset && !flush && (!m_out || (ev && resp_ready));
        chk("m_resp_valid", 32'(resp_valid), 32'(ev));
        chk("m_req_ready", 32'(req_ready), 32'(er));
        chk("m_resp_addr", resp_addr, ev ? m_addr : 32'd0);
        chk("m_resp_fault", 32'(resp_fault), ev ? 32'(m_fault) : 32'd0);
        if (!ev || m_ikn) begin
            chk("m_resp_instr", resp_instr, ev ? m_instr : NOP);
        end
        if (reset || flush) begin
            m_out = 1'b0;
        end else begin
            if (ev && resp_ready) m_out = 1'b0;
            if (req_valid && er) begin
                m_out      = 1'b1;
                m_addr     = req_addr;
                m_fault    = bad_addr(req_addr);
                m_ready_at = m_cyc + LAT;
            end
            if (m_out && (m_cyc + 1 == m_ready_at)) begin
                if (m_fault) begin
                    m_instr = NOP;
                    m_ikn   = 1'b1;
                end else begin
                    m_instr = m_mem[m_addr >> 2];
                    m_ikn   = m_known[m_addr >> 2];
                end
            end
        end
        if (load_we && !bad_addr(load_addr)) begin
            m_mem[load_addr >> 2]   = load_data;
            m_known[load_addr >> 2] = 1'b1;
        end
        m_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int exp_lat, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            req_valid = 1'b0;
        end while (!resp_valid && n < 12);
        chk(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef, input string name);
        req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
        #1;
        chk({name, "_rdy"}, 32'(req_ready), 32'd1);
        wait_resp(LAT, {name, "_lat"});
        chk({name, "_instr"}, resp_instr, ei);
        chk({name, "_addr"}, resp_addr, a);
        chk({name, "_fault"}, 32'(resp_fault), 32'(ef));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_instr", resp_instr, NOP);
        chk("rst_addr", resp_addr, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd1);

        load(32'h0000_000C, 32'h0050_0093);
        load(32'h0000_0010, 32'h00A0_0113);
        load(32'h0000_0014, 32'h1111_1111);
        load(32'h0000_0FFC, 32'hCAFE_F00D);
        load(32'h0000_000D, 32'hDEAD_BEEF);
        load(32'h0000_1000, 32'hBADB_AD00);

        // Basic fetch with latency 2, response held by consumer
        req_valid = 1'b1; req_addr = 32'h0000_000C; resp_ready = 1'b0;
        wait_resp(2, "lat_first");
        chk("first_instr", resp_instr, 32'h0050_0093);
        chk("first_addr", resp_addr, 32'h0000_000C);

        // Stall then back-to-back accept while retiring
        req_valid = 1'b1; req_addr = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", 32'(req_ready), 32'd0);
            tick();
            chk("stall_instr", resp_instr, 32'h0050_0093);
        end
        resp_ready = 1'b1;
        #1;
        chk("b2b_ready", 32'(req_ready), 32'd1);
        wait_resp(2, "lat_b2b");
        chk("b2b_instr", resp_instr, 32'h00A0_0113);
        chk("b2b_addr", resp_addr, 32'h0000_0010);
        tick();

        fetch(32'h0000_0006, NOP, 1'b1, "misalign");
        fetch(32'h0000_1000, NOP, 1'b1, "range");
        fetch(32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, "lastword");
        fetch(32'h0000_000C, 32'h0050_0093, 1'b0, "noclobber");

        // Flush while waiting
        req_valid = 1'b1; req_addr = 32'h0000_0014;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flw_idle", 32'(req_ready), 32'd1);
        repeat (4) begin
            tick();
            chk("flw_valid", 32'(resp_valid), 32'd0);
        end

        // Flush while presenting
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0014;
        wait_resp(2, "lat_flr");
        chk("flr_instr", resp_instr, 32'h1111_1111);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flr_valid", 32'(resp_valid), 32'd0);
        chk("flr_instr0", resp_instr, NOP);
        #1;
        chk("flr_idle", 32'(req_ready), 32'd1);

        // Flush in the same cycle as a request
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_000C;
        #1;
        chk("flq_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        repeat (3) begin
            tick();
            chk("flq_valid", 32'(resp_valid), 32'd0);
        end

        // Reset one cycle after accept drops the request; memory survives
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_000C;
        tick();
        req_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("rsti_valid", 32'(resp_valid), 32'd0);
        end
        fetch(32'h0000_000C, 32'h0050_0093, 1'b0, "postrst");

        // Load colliding with the read edge returns old data
        req_valid = 1'b1; req_addr = 32'h0000_0010;
        tick();
        req_valid = 1'b0;
        load_we = 1'b1; load_addr = 32'h0000_0010; load_data = 32'h2222_2222;
        tick();
        load_we = 1'b0;
        chk("coll_valid", 32'(resp_valid), 32'd1);
        chk("coll_old", resp_instr, 32'h00A0_0113);
        tick();
        fetch(32'h0000_0010, 32'h2222_2222, 1'b0, "coll_new");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
